// File: rtl/probe_sched_pkg.sv
// Shared types and constants for the probe dump scheduler: window states,
// the sample record carried from a channel slot to the dump writer, and the
// saturating drop-counter helper.
package probe_sched_pkg;

    localparam int MAX_CH      = 16;
    localparam int DROP_W      = 16;
    localparam int DROP_INC_W  = 5;
    localparam int REC_CH_W    = 4;
    localparam int REC_TIME_W  = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef struct {
        logic [REC_CH_W-1:0]   ch;
        logic [REC_TIME_W-1:0] ts;
        real                   data;
    } rec_t;

    // Adds this edge's drops to the running count, pinning at all-ones.
    function automatic logic [DROP_W-1:0] sat_add_drop(
        input logic [DROP_W-1:0]     acc,
        input logic [DROP_INC_W-1:0] inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, acc} + (DROP_W+1)'(inc);
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/probe_dump_scheduler_if.sv
// Valid/ready record stream from the scheduler to the dump sink.
interface probe_dump_scheduler_if #(
    parameter int CH_W  = 2,
    parameter int CNT_W = 64
);
    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_time;
    real              wr_data;

    modport master (output wr_valid, output wr_ch, output wr_time, output wr_data,
                    input  wr_ready);
    modport slave  (input  wr_valid, input  wr_ch, input  wr_time, input  wr_data,
                    output wr_ready);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner, so every
// requester is served within N grants. The grant is masked by en and the
// pointer only moves when a grant is actually issued.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_any
);

    logic [IDX_W-1:0] last_r;

    // Rotating priority search over the request vector.
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             hit;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        hit     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand      = IDX_W'((int'(last_r) + k) % N);
            hit       = en & req[cand] & ~gnt_any;
            gnt[cand] = gnt[cand] | hit;
            gnt_idx   = hit ? cand : gnt_idx;
            gnt_any   = gnt_any | hit;
        end
    end

    // Remember the winner; reset points at N-1 so channel 0 goes first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_r <= IDX_W'(N - 1);
        end else if (gnt_any) begin
            last_r <= gnt_idx;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/probe_dump_scheduler.sv
// Probe dump scheduler: gates per-channel samples by a cycle-count capture
// window, parks them in one slot per channel and serializes them onto a
// single valid/ready record stream through a round-robin arbiter.
module probe_dump_scheduler
    import probe_sched_pkg::*;
#(
    parameter int              N_CH    = 4,
    parameter longint unsigned T_START = 0,
    parameter longint unsigned T_END   = 1000,
    parameter int              CNT_W   = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [N_CH-1:0]       ch_valid,
    input  real                   ch_data [N_CH],
    probe_dump_scheduler_if.master wr,
    output logic [DROP_W-1:0]     drop_cnt,
    output logic                  done
);

    localparam int               CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [CNT_W-1:0] T_START_C = CNT_W'(T_START);
    localparam logic [CNT_W-1:0] T_END_C   = CNT_W'(T_END);

    logic [CNT_W-1:0]      cnt_r;
    state_t                state_r, state_s;
    logic                  ge_start_s, le_end_s, window_s;
    logic [N_CH-1:0]       slot_v_r, capt_s, take_s, drop_s;
    rec_t                  slot_r [N_CH];
    rec_t                  out_r;
    logic                  out_valid_r, grant_en_s, gnt_any_s;
    logic [CH_W-1:0]       gnt_idx_s;
    logic [DROP_INC_W-1:0] drop_n_s;
    logic [DROP_W-1:0]     drop_cnt_r;

    // cnt + 1 > T_START is cnt >= T_START without a constant compare at T_START = 0.
    assign ge_start_s = ({1'b0, cnt_r} + (CNT_W+1)'(1)) > {1'b0, T_START_C};
    assign le_end_s   = cnt_r <= T_END_C;
    assign window_s   = en & ge_start_s & le_end_s;
    assign grant_en_s = ~out_valid_r | wr.wr_ready;
    assign capt_s     = ch_valid & {N_CH{window_s}};
    assign drop_s     = capt_s & slot_v_r & ~take_s;

    rr_arbiter #(.N(N_CH), .IDX_W(CH_W)) u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (slot_v_r),
        .en      (grant_en_s),
        .gnt     (take_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Free-running cycle counter, frozen while disabled, pinned at all-ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Window state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Window next state from the registered counter; enable low wins.
    always_comb begin
        state_s = state_r;
        if (!en) begin
            state_s = IDLE;
        end else if (!ge_start_s) begin
            state_s = ARMED;
        end else if (le_end_s) begin
            state_s = CAPTURE;
        end else begin
            state_s = DONE;
        end
    end

    // Per-channel slots: capture into a free or just-granted slot, clear on grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_v_r <= '0;
            for (int i = 0; i < N_CH; i++) begin
                slot_r[i].ch   <= '0;
                slot_r[i].ts   <= '0;
                slot_r[i].data <= 0.0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (capt_s[i] && (!slot_v_r[i] || take_s[i])) begin
                    slot_v_r[i]    <= 1'b1;
                    slot_r[i].ch   <= REC_CH_W'(i);
                    slot_r[i].ts   <= REC_TIME_W'(cnt_r);
                    slot_r[i].data <= ch_data[i];
                end else if (take_s[i]) begin
                    slot_v_r[i] <= 1'b0;
                end else begin
                    slot_v_r[i] <= slot_v_r[i];
                end
            end
        end
    end

    // Number of channels losing a sample on this edge.
    always_comb begin
        drop_n_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            drop_n_s = drop_n_s + DROP_INC_W'(drop_s[i]);
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt_r <= '0;
        end else begin
            drop_cnt_r <= sat_add_drop(drop_cnt_r, drop_n_s);
        end
    end

    // Output record register: load on grant, empty on a transfer with nothing new.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            out_r.ch    <= '0;
            out_r.ts    <= '0;
            out_r.data  <= 0.0;
        end else if (grant_en_s && gnt_any_s) begin
            out_valid_r <= 1'b1;
            out_r       <= slot_r[gnt_idx_s];
        end else if (out_valid_r && wr.wr_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign wr.wr_valid = out_valid_r;
    assign wr.wr_ch    = CH_W'(out_r.ch);
    assign wr.wr_time  = CNT_W'(out_r.ts);
    assign wr.wr_data  = out_r.data;
    assign drop_cnt    = drop_cnt_r;
    assign done        = (state_r == DONE) && (slot_v_r == '0) && !out_valid_r;

endmodule

// File: tb/tb_probe_dump_scheduler.sv
// Directed bench for probe_dump_scheduler with a 10..20 capture window.
module tb_probe_dump_scheduler;
    import probe_sched_pkg::*;

    logic        clk;
    logic        rstn;
    logic        en;
    logic [3:0]  ch_valid;
    real         ch_data [4];
    logic [15:0] drop_cnt;
    logic        done;
    int          checks;
    int          failures;
    int          bcnt;
    int          n;

    probe_dump_scheduler_if #(.CH_W(2), .CNT_W(64)) wr ();

    probe_dump_scheduler #(.N_CH(4), .T_START(10), .T_END(20), .CNT_W(64)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .ch_valid (ch_valid),
        .ch_data  (ch_data),
        .wr       (wr),
        .drop_cnt (drop_cnt),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_r(input string tag, input real obs, input real exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
        end
    endtask

    // One clock edge; bcnt mirrors the DUT counter while en is high.
    task automatic step();
        @(posedge clk);
        #1;
        bcnt++;
    endtask

    task automatic step_to(input int t);
        for (int k = 0; k < 40 && bcnt < t; k++) step();
    endtask

    task automatic restart();
        rstn     = 1'b0;
        en       = 1'b0;
        ch_valid = 4'b0000;
        #2;
        rstn = 1'b1;
        en   = 1'b1;
        bcnt = 0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        bcnt        = 0;
        rstn        = 1'b0;
        en          = 1'b0;
        ch_valid    = 4'b0000;
        wr.wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) ch_data[i] = 0.0;
        #1;

        // Reset values
        chk("rst_valid", 64'(wr.wr_valid), 64'(0));
        chk("rst_ch", 64'(wr.wr_ch), 64'(0));
        chk("rst_time", wr.wr_time, 64'(0));
        chk_r("rst_data", wr.wr_data, 0.0);
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_done", 64'(done), 64'(0));

        // Window gating: ch0 strobes every cycle, only 10..20 get through
        restart();
        wr.wr_ready = 1'b1;
        ch_valid    = 4'b0001;
        ch_data[0]  = 3.5;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (wr.wr_valid) begin
                chk("win_ch", 64'(wr.wr_ch), 64'(0));
                chk("win_time", wr.wr_time, 64'(10 + n));
                if (n == 0) chk("win_done_early", 64'(done), 64'(0));
                n++;
            end
        end
        chk("win_count", 64'(n), 64'(11));
        chk("win_done", 64'(done), 64'(1));
        chk("win_drop", 64'(drop_cnt), 64'(0));
        ch_valid = 4'b0000;

        // Fairness: all four channels at cnt 12, drained in order 0..3
        restart();
        wr.wr_ready = 1'b1;
        for (int i = 0; i < 4; i++) ch_data[i] = 0.25 + i;
        step_to(12);
        ch_valid = 4'b1111;
        step();
        ch_valid = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_valid", 64'(wr.wr_valid), 64'(1));
            chk("rr_ch", 64'(wr.wr_ch), 64'(i));
            chk("rr_time", wr.wr_time, 64'(12));
            chk_r("rr_data", wr.wr_data, 0.25 + i);
        end
        step();
        chk("rr_empty", 64'(wr.wr_valid), 64'(0));

        // Backpressure, drop and stall stability (ch0 occupies the output first)
        restart();
        wr.wr_ready = 1'b0;
        ch_data[0]  = 0.5;
        step_to(11);
        ch_valid = 4'b0001;
        step();
        ch_valid   = 4'b0100;
        ch_data[2] = 2.25;
        step();
        chk("bp_out_ch", 64'(wr.wr_ch), 64'(0));
        chk("bp_out_time", wr.wr_time, 64'(11));
        ch_data[2] = 9.0;
        step();
        ch_valid = 4'b0000;
        chk("bp_drop", 64'(drop_cnt), 64'(1));
        for (int s = 0; s < 5; s++) begin
            chk("stall_valid", 64'(wr.wr_valid), 64'(1));
            chk("stall_ch", 64'(wr.wr_ch), 64'(0));
            chk("stall_time", wr.wr_time, 64'(11));
            chk_r("stall_data", wr.wr_data, 0.5);
            step();
        end
        wr.wr_ready = 1'b1;
        step();
        chk("bp_ch2_ch", 64'(wr.wr_ch), 64'(2));
        chk("bp_ch2_time", wr.wr_time, 64'(12));
        chk_r("bp_ch2_data", wr.wr_data, 2.25);
        step();
        chk("bp_empty", 64'(wr.wr_valid), 64'(0));
        chk("bp_drop_final", 64'(drop_cnt), 64'(1));

        // Same-edge reload: ch1 at 14 and 15, no drop
        restart();
        wr.wr_ready = 1'b1;
        step_to(14);
        ch_valid   = 4'b0010;
        ch_data[1] = 1.25;
        step();
        ch_data[1] = 1.75;
        step();
        ch_valid = 4'b0000;
        chk("re_ch_a", 64'(wr.wr_ch), 64'(1));
        chk("re_time_a", wr.wr_time, 64'(14));
        chk_r("re_data_a", wr.wr_data, 1.25);
        step();
        chk("re_valid_b", 64'(wr.wr_valid), 64'(1));
        chk("re_time_b", wr.wr_time, 64'(15));
        chk_r("re_data_b", wr.wr_data, 1.75);
        step();
        chk("re_empty", 64'(wr.wr_valid), 64'(0));
        chk("re_drop", 64'(drop_cnt), 64'(0));

        // Async reset at cnt 15 with records pending and a drop counted
        restart();
        wr.wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) ch_data[i] = 5.0 + i;
        step_to(13);
        ch_valid = 4'b1111;
        step();
        ch_valid = 4'b0010;
        step();
        ch_valid = 4'b0000;
        chk("ar_pre_valid", 64'(wr.wr_valid), 64'(1));
        chk("ar_pre_drop", 64'(drop_cnt), 64'(1));
        rstn = 1'b0;
        #1;
        chk("ar_valid", 64'(wr.wr_valid), 64'(0));
        chk("ar_drop", 64'(drop_cnt), 64'(0));
        chk("ar_cnt", dut.cnt_r, 64'(0));
        chk("ar_state", 64'(dut.state_r), 64'(IDLE));
        chk("ar_done", 64'(done), 64'(0));
        #3;
        rstn        = 1'b1;
        bcnt        = 0;
        wr.wr_ready = 1'b1;
        ch_valid    = 4'b0001;
        ch_data[0]  = 7.0;
        for (int c = 0; c < 30 && !wr.wr_valid; c++) step();
        ch_valid = 4'b0000;
        chk("ar_resume_valid", 64'(wr.wr_valid), 64'(1));
        chk("ar_resume_ch", 64'(wr.wr_ch), 64'(0));
        chk("ar_resume_time", wr.wr_time, 64'(10));
        chk_r("ar_resume_data", wr.wr_data, 7.0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
